// File: rtl/omp_ram_dp.sv
// rtl/omp_ram_dp.sv - true dual-port RAM with byte enables, write modes, output register and clear engine
//
// Purpose: dual-port word store for the OMP datapath. Both ports read and
// write independently every cycle once the post-reset clear engine has
// zeroed the array.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   init_busy           high while the clear engine runs (port requests ignored)
//   addrN, ceN          port N address and access enable
//   weN                 port N byte write enables (bit i -> dN[8i+7:8i])
//   dN                  port N write data
//   qN, qN_vld          port N read data and one-cycle valid pulse per access
module omp_ram_dp #(
    parameter int DWIDTH         = 32,
    parameter int AWIDTH         = 8,
    parameter int MEM_SIZE       = 256,
    parameter int OUT_REG        = 1,
    parameter int WRITE_MODE     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  init_busy,
    input  logic [AWIDTH-1:0]     addr0,
    input  logic                  ce0,
    input  logic [DWIDTH/8-1:0]   we0,
    input  logic [DWIDTH-1:0]     d0,
    output logic [DWIDTH-1:0]     q0,
    output logic                  q0_vld,
    input  logic [AWIDTH-1:0]     addr1,
    input  logic                  ce1,
    input  logic [DWIDTH/8-1:0]   we1,
    input  logic [DWIDTH-1:0]     d1,
    output logic [DWIDTH-1:0]     q1,
    output logic                  q1_vld
);

    localparam int NB = DWIDTH / 8;
    localparam int IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(MEM_SIZE - 1);
    localparam logic [AWIDTH:0] SIZE_A   = (AWIDTH + 1)'(MEM_SIZE);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic [IW-1:0] clr_cnt;
    logic clr_we;

    logic [DWIDTH-1:0] ram [0:MEM_SIZE-1];

    logic acc0, acc1;
    logic in0, in1;
    logic [IW-1:0] idx0, idx1;
    logic [DWIDTH-1:0] old0, old1;
    logic [DWIDTH-1:0] rd0, rd1;
    logic [DWIDTH-1:0] r0_data, r1_data;
    logic r0_vld, r1_vld;

    function automatic logic [DWIDTH-1:0] merge_bytes(
        input logic [DWIDTH-1:0] old_w,
        input logic [NB-1:0]     be,
        input logic [DWIDTH-1:0] new_w
    );
        logic [DWIDTH-1:0] r;
        r = old_w;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                r[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return r;
    endfunction

    // Clear engine state and word counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR) begin
                clr_cnt <= clr_cnt + IW'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        init_busy = 1'b0;
        clr_we    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                init_busy = 1'b1;
                clr_we    = 1'b1;
                if (clr_cnt == LAST_IDX) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    assign acc0 = (state_q == ST_READY) && ce0;
    assign acc1 = (state_q == ST_READY) && ce1;
    assign in0  = {1'b0, addr0} < SIZE_A;
    assign in1  = {1'b0, addr1} < SIZE_A;
    assign idx0 = addr0[IW-1:0];
    assign idx1 = addr1[IW-1:0];
    assign old0 = in0 ? ram[idx0] : '0;
    assign old1 = in1 ? ram[idx1] : '0;

    // Read data is taken from the array before this edge's writes land, so a
    // reader colliding with the other port's write always sees the old word.
    // Only the writing port's own q honours WRITE_MODE.
    always_comb begin
        rd0 = '0;
        if (in0) begin
            if (we0 == '0) begin
                rd0 = old0;
            end else if (WRITE_MODE == 0) begin
                rd0 = merge_bytes(old0, we0, d0);
            end else if (WRITE_MODE == 1) begin
                rd0 = old0;
            end else begin
                rd0 = r0_data;
            end
        end
    end

    always_comb begin
        rd1 = '0;
        if (in1) begin
            if (we1 == '0) begin
                rd1 = old1;
            end else if (WRITE_MODE == 0) begin
                rd1 = merge_bytes(old1, we1, d1);
            end else if (WRITE_MODE == 1) begin
                rd1 = old1;
            end else begin
                rd1 = r1_data;
            end
        end
    end

    // Port 1 lanes are assigned first so that port 0 overrides any byte both
    // ports enable on a same-address collision.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            ram[clr_cnt] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (acc1 && in1 && we1[b]) begin
                    ram[idx1][8*b +: 8] <= d1[8*b +: 8];
                end
            end
            for (int b = 0; b < NB; b++) begin
                if (acc0 && in0 && we0[b]) begin
                    ram[idx0][8*b +: 8] <= d0[8*b +: 8];
                end
            end
        end
    end

    // First read stage; data holds when the port is idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r0_data <= '0;
            r0_vld  <= 1'b0;
            r1_data <= '0;
            r1_vld  <= 1'b0;
        end else if (state_q != ST_READY) begin
            r0_data <= '0;
            r0_vld  <= 1'b0;
            r1_data <= '0;
            r1_vld  <= 1'b0;
        end else begin
            r0_vld <= ce0;
            r1_vld <= ce1;
            if (ce0) begin
                r0_data <= rd0;
            end
            if (ce1) begin
                r1_data <= rd1;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q0     <= '0;
                    q0_vld <= 1'b0;
                    q1     <= '0;
                    q1_vld <= 1'b0;
                end else begin
                    q0     <= r0_data;
                    q0_vld <= r0_vld;
                    q1     <= r1_data;
                    q1_vld <= r1_vld;
                end
            end
        end else begin : g_noreg
            assign q0     = r0_data;
            assign q0_vld = r0_vld;
            assign q1     = r1_data;
            assign q1_vld = r1_vld;
        end
    endgenerate

endmodule

// File: tb/tb_omp_ram_dp.sv
// tb/tb_omp_ram_dp.sv - self-checking bench for omp_ram_dp across three configurations
module tb_omp_ram_dp;

    logic        clk;
    logic        rst;
    logic [8:0]  addr0, addr1;
    logic        ce0, ce1;
    logic [3:0]  we0, we1;
    logic [31:0] d0, d1;

    logic [31:0] q0o [3];
    logic [31:0] q1o [3];
    logic        v0o [3];
    logic        v1o [3];
    logic        bo  [3];
    logic [66:0] obs [3];

    int n_tests = 0;
    int n_fail  = 0;

    // Instance k: A = latency 2 write-first, B = latency 1 read-first,
    // C = latency 1 no-change with a 200-word array.
    int M_SIZE [3] = '{256, 256, 200};
    int M_LAT  [3] = '{2, 1, 1};
    int M_MODE [3] = '{0, 1, 2};

    omp_ram_dp #(.DWIDTH(32), .AWIDTH(9), .MEM_SIZE(256), .OUT_REG(1), .WRITE_MODE(0), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .reset(rst), .init_busy(bo[0]),
        .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0o[0]), .q0_vld(v0o[0]),
        .addr1(addr1), .ce1(ce1), .we1(we1), .d1(d1), .q1(q1o[0]), .q1_vld(v1o[0])
    );

    omp_ram_dp #(.DWIDTH(32), .AWIDTH(9), .MEM_SIZE(256), .OUT_REG(0), .WRITE_MODE(1), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .reset(rst), .init_busy(bo[1]),
        .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0o[1]), .q0_vld(v0o[1]),
        .addr1(addr1), .ce1(ce1), .we1(we1), .d1(d1), .q1(q1o[1]), .q1_vld(v1o[1])
    );

    omp_ram_dp #(.DWIDTH(32), .AWIDTH(9), .MEM_SIZE(200), .OUT_REG(0), .WRITE_MODE(2), .CLEAR_ON_RESET(1)) u_c (
        .clk(clk), .reset(rst), .init_busy(bo[2]),
        .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0o[2]), .q0_vld(v0o[2]),
        .addr1(addr1), .ce1(ce1), .we1(we1), .d1(d1), .q1(q1o[2]), .q1_vld(v1o[2])
    );

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            obs[k] = {q0o[k], v0o[k], q1o[k], v1o[k], bo[k]};
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: word arrays, remaining clear cycles, and the value each
    // port presents one cycle after an access (vq/vv) plus one cycle later (pq/pv).
    logic [31:0] mem [3][512];
    int          busy_left [3];
    logic [31:0] vq0 [3], vq1 [3], pq0 [3], pq1 [3];
    logic        vv0 [3], vv1 [3], pv0 [3], pv1 [3];
    logic [66:0] exp_o [3];

    function automatic logic [31:0] byte_mask(input logic [3:0] w);
        return {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
    endfunction

    function automatic logic [31:0] port_res(input int k, input logic [8:0] a, input logic [3:0] w,
                                             input logic [31:0] d, input logic [31:0] held);
        logic [31:0] old;
        if (int'(a) >= M_SIZE[k]) return 32'h0;
        old = mem[k][a];
        if (w == 4'h0) return old;
        if (M_MODE[k] == 0) return (old & ~byte_mask(w)) | (d & byte_mask(w));
        if (M_MODE[k] == 1) return old;
        return held;
    endfunction

    task automatic model_write(input int k, input logic [8:0] a, input logic [3:0] w, input logic [31:0] d);
        if (int'(a) < M_SIZE[k]) begin
            mem[k][a] = (mem[k][a] & ~byte_mask(w)) | (d & byte_mask(w));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            busy_left[k] = M_SIZE[k];
            vq0[k] = '0; vq1[k] = '0; pq0[k] = '0; pq1[k] = '0;
            vv0[k] = 1'b0; vv1[k] = 1'b0; pv0[k] = 1'b0; pv1[k] = 1'b0;
            for (int i = 0; i < 512; i++) mem[k][i] = '0;
            exp_o[k] = {32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
        end
    endtask

    task automatic model_edge();
        logic [31:0] r0, r1;
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++) begin
                pq0[k] = vq0[k]; pv0[k] = vv0[k];
                pq1[k] = vq1[k]; pv1[k] = vv1[k];
                if (busy_left[k] > 0) begin
                    busy_left[k]--;
                    vv0[k] = 1'b0;
                    vv1[k] = 1'b0;
                end else begin
                    r0 = port_res(k, addr0, we0, d0, vq0[k]);
                    r1 = port_res(k, addr1, we1, d1, vq1[k]);
                    if (ce1) model_write(k, addr1, we1, d1);
                    if (ce0) model_write(k, addr0, we0, d0);
                    vv0[k] = ce0;
                    vv1[k] = ce1;
                    if (ce0) vq0[k] = r0;
                    if (ce1) vq1[k] = r1;
                end
                if (M_LAT[k] == 1)
                    exp_o[k] = {vq0[k], vv0[k], vq1[k], vv1[k], busy_left[k] > 0};
                else
                    exp_o[k] = {pq0[k], pv0[k], pq1[k], pv1[k], busy_left[k] > 0};
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        ce0 = 1'b0; ce1 = 1'b0; we0 = 4'h0; we1 = 4'h0;
    endtask

    task automatic test_reset();
        int busy_len;
        logic seen_vld;
        rst = 1'b1;
        idle();
        addr0 = '0; addr1 = '0; d0 = '0; d1 = '0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (obs[k] !== exp_o[k]) begin
                    n_fail++;
                    $display("FAIL reset_hold[%0d] got %h expected %h", k, obs[k], exp_o[k]);
                end
            end
        end
        rst = 1'b0;
        busy_len = -1;
        seen_vld = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            ce0 = 1'b1; ce1 = 1'b1; we0 = 4'h0; we1 = 4'h0;
            addr0 = 9'($urandom_range(0, 255));
            addr1 = 9'($urandom_range(0, 255));
            step();
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (obs[k] !== exp_o[k]) begin
                    n_fail++;
                    $display("FAIL clear_run[%0d] cyc %0d got %h expected %h", k, i, obs[k], exp_o[k]);
                end
            end
            if (v0o[0] || v0o[1] || v1o[0] || v1o[1]) seen_vld = 1'b1;
            if (!bo[0]) begin
                busy_len = i;
                break;
            end
        end
        n_tests++;
        if (busy_len != 256) begin
            n_fail++;
            $display("FAIL busy_len got %0d expected 256", busy_len);
        end
        n_tests++;
        if (seen_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_vld got %0b expected 0", seen_vld);
        end
        addr0 = 9'd0; addr1 = 9'd128; ce0 = 1'b1; ce1 = 1'b1;
        step();
        addr0 = 9'd255; ce1 = 1'b0;
        step();
        n_tests++;
        if (q0o[0] !== 32'h0 || v0o[0] !== 1'b1 || q0o[1] !== 32'h0 || v0o[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_read got A=%h/%b B=%h/%b expected 0/1", q0o[0], v0o[0], q0o[1], v0o[1]);
        end
        idle();
        step();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs[k] !== exp_o[k]) begin
                n_fail++;
                $display("FAIL clear_read_tail[%0d] got %h expected %h", k, obs[k], exp_o[k]);
            end
        end
    endtask

    task automatic test_latency();
        addr0 = 9'd5; we0 = 4'hF; d0 = 32'hDEADBEEF; ce0 = 1'b1;
        step();
        we0 = 4'h0;
        step();
        n_tests++;
        if (q0o[1] !== 32'hDEADBEEF || v0o[1] !== 1'b1 || v0o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL lat1 got B=%h/%b A_vld=%b expected deadbeef/1 A_vld=1", q0o[1], v0o[1], v0o[0]);
        end
        idle();
        step();
        n_tests++;
        if (q0o[0] !== 32'hDEADBEEF || v0o[0] !== 1'b1 || v0o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL lat2 got A=%h/%b B_vld=%b expected deadbeef/1 B_vld=0", q0o[0], v0o[0], v0o[1]);
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs[k] !== exp_o[k]) begin
                n_fail++;
                $display("FAIL latency_model[%0d] got %h expected %h", k, obs[k], exp_o[k]);
            end
        end
    endtask

    task automatic test_byte_enables();
        addr0 = 9'd7; we0 = 4'hF; d0 = 32'h11223344; ce0 = 1'b1;
        step();
        we0 = 4'b0101; d0 = 32'hAABBCCDD;
        step();
        n_tests++;
        if (q0o[1] !== 32'h11223344 || q0o[2] !== 32'hDEADBEEF || v0o[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL be_modes got B=%h C=%h/%b expected 11223344 deadbeef/1", q0o[1], q0o[2], v0o[2]);
        end
        idle();
        step();
        n_tests++;
        if (q0o[0] !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL be_wfirst got %h expected 11bb33dd", q0o[0]);
        end
        ce0 = 1'b1; we0 = 4'h0;
        step();
        idle();
        n_tests++;
        if (q0o[1] !== 32'h11BB33DD || q0o[2] !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL be_readback got B=%h C=%h expected 11bb33dd", q0o[1], q0o[2]);
        end
        step();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs[k] !== exp_o[k]) begin
                n_fail++;
                $display("FAIL be_model[%0d] got %h expected %h", k, obs[k], exp_o[k]);
            end
        end
    endtask

    task automatic test_collision();
        addr0 = 9'd9; addr1 = 9'd9;
        ce0 = 1'b1; we0 = 4'hF; d0 = 32'h01010101;
        ce1 = 1'b1; we1 = 4'h3; d1 = 32'hFFFFFFFF;
        step();
        ce0 = 1'b0; we0 = 4'h0; we1 = 4'hC;
        step();
        ce0 = 1'b1; we1 = 4'h0;
        step();
        n_tests++;
        if (q0o[1] !== 32'hFFFF0101 || q1o[2] !== 32'hFFFF0101) begin
            n_fail++;
            $display("FAIL collision got B.q0=%h C.q1=%h expected ffff0101", q0o[1], q1o[2]);
        end
        idle();
        step();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs[k] !== exp_o[k]) begin
                n_fail++;
                $display("FAIL collision_model[%0d] got %h expected %h", k, obs[k], exp_o[k]);
            end
        end
    endtask

    task automatic test_read_during_write();
        addr0 = 9'd3; we0 = 4'hF; d0 = 32'h12345678; ce0 = 1'b1;
        step();
        d0 = 32'h00000055; addr1 = 9'd3; ce1 = 1'b1; we1 = 4'h0;
        step();
        n_tests++;
        if (q1o[1] !== 32'h12345678 || q1o[2] !== 32'h12345678 || v1o[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL rdw_old got B=%h C=%h expected 12345678", q1o[1], q1o[2]);
        end
        ce0 = 1'b0; we0 = 4'h0;
        step();
        n_tests++;
        if (q1o[1] !== 32'h00000055 || q1o[0] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL rdw_new got B=%h A=%h expected 00000055 12345678", q1o[1], q1o[0]);
        end
        idle();
        step();
        n_tests++;
        if (q1o[0] !== 32'h00000055) begin
            n_fail++;
            $display("FAIL rdw_new_a got %h expected 00000055", q1o[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ce0 = 1'($urandom_range(0, 3) != 0);
            ce1 = 1'($urandom_range(0, 3) != 0);
            we0 = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            we1 = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            d0 = $urandom;
            d1 = $urandom;
            addr0 = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(190, 511)) : 9'($urandom_range(0, 15));
            addr1 = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(190, 511)) : 9'($urandom_range(0, 15));
            step();
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (obs[k] !== exp_o[k]) begin
                    n_fail++;
                    $display("FAIL random[%0d] cyc %0d got %h expected %h", k, i, obs[k], exp_o[k]);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_clear();
        int busy_len;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs[k] !== exp_o[k]) begin
                n_fail++;
                $display("FAIL async_reset_ready[%0d] got %h expected %h", k, obs[k], exp_o[k]);
            end
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs[k] !== exp_o[k]) begin
                n_fail++;
                $display("FAIL async_reset_clear[%0d] got %h expected %h", k, obs[k], exp_o[k]);
            end
        end
        step();
        rst = 1'b0;
        busy_len = -1;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (!bo[0]) begin
                busy_len = i;
                break;
            end
        end
        n_tests++;
        if (busy_len != 256) begin
            n_fail++;
            $display("FAIL restart_busy_len got %0d expected 256", busy_len);
        end
        addr0 = 9'd300; we0 = 4'hF; d0 = 32'hCAFEF00D; ce0 = 1'b1;
        step();
        we0 = 4'h0;
        step();
        addr0 = 9'd44;
        step();
        n_tests++;
        if (q0o[0] !== 32'h0 || v0o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_read got %h/%b expected 0/1", q0o[0], v0o[0]);
        end
        idle();
        step();
        n_tests++;
        if (q0o[0] !== 32'h0 || v0o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_alias got %h/%b expected 0/1", q0o[0], v0o[0]);
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs[k] !== exp_o[k]) begin
                n_fail++;
                $display("FAIL oor_model[%0d] got %h expected %h", k, obs[k], exp_o[k]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_byte_enables();
        test_collision();
        test_read_during_write();
        test_random();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
